// File: rtl/fetch_ifid.sv
// Fetch stage and IF/ID pipeline register.
// Handles stall, EX-resolved branch redirect with flush, and a terminal HALT state.
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallCtrl,
  input  logic        brTaken,
  input  logic [15:0] brTarget,
  input  logic        halt_ID,
  input  logic [15:0] instr_mem,
  output logic [15:0] pc_out,
  output logic [15:0] instr_IFID,
  output logic [15:0] pcPlus2_IFID,
  output logic        valid_IFID,
  output logic [2:0]  Rd1Addr_IFID,
  output logic [2:0]  Rd2Addr_IFID,
  output logic        bubble,
  output logic        halted,
  output logic [15:0] stallCnt
);

  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;

  logic state;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fetch / IF-ID boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      pc_out       <= RESET_PC;
      instr_IFID   <= NOP_INSTR;
      pcPlus2_IFID <= RESET_PC + 16'd2;
      valid_IFID   <= 1'b0;
      stallCnt     <= 16'd0;
    end else if (state == RUN) begin
      if (brTaken) begin
        pc_out       <= brTarget;
        instr_IFID   <= NOP_INSTR;
        pcPlus2_IFID <= brTarget + 16'd2;
        valid_IFID   <= 1'b0;
      end else if (stallCtrl) begin
        stallCnt <= satInc(stallCnt);
      end else if (halt_ID && valid_IFID) begin
        // pc_out and pcPlus2_IFID stay frozen for good
        state      <= HALT;
        instr_IFID <= NOP_INSTR;
        valid_IFID <= 1'b0;
      end else begin
        pc_out       <= pc_out + 16'd2;
        instr_IFID   <= instr_mem;
        pcPlus2_IFID <= pc_out + 16'd2;
        valid_IFID   <= 1'b1;
      end
    end
  end

  assign halted       = (state == HALT);
  assign bubble       = stallCtrl & ~brTaken & (state == RUN);
  assign Rd1Addr_IFID = instr_IFID[10:8];
  assign Rd2Addr_IFID = instr_IFID[7:5];

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: cycle model compared every cycle plus
// directed literal checks on reset, stall, redirect, halt, wrap and saturation.
module tb_fetch_ifid;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallCtrl, brTaken, halt_ID;
  logic [15:0] brTarget, instr_mem;
  logic [15:0] pc_out, instr_IFID, pcPlus2_IFID, stallCnt;
  logic        valid_IFID, bubble, halted;
  logic [2:0]  Rd1Addr_IFID, Rd2Addr_IFID;

  int checks = 0;
  int errors = 0;

  fetch_ifid #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .stallCtrl(stallCtrl), .brTaken(brTaken),
    .brTarget(brTarget), .halt_ID(halt_ID), .instr_mem(instr_mem),
    .pc_out(pc_out), .instr_IFID(instr_IFID), .pcPlus2_IFID(pcPlus2_IFID),
    .valid_IFID(valid_IFID), .Rd1Addr_IFID(Rd1Addr_IFID),
    .Rd2Addr_IFID(Rd2Addr_IFID), .bubble(bubble), .halted(halted),
    .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  // memory returns its own address as data
  assign instr_mem = pc_out;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the fetch stage
  logic [15:0] mPc, mInstr, mPlus2, mCnt;
  logic        mValid, mHalted;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPc = 16'h0000; mInstr = 16'h0800; mPlus2 = 16'h0002;
      mValid = 1'b0; mHalted = 1'b0; mCnt = 16'h0000;
    end else if (!mHalted) begin
      if (brTaken) begin
        mPc = brTarget; mInstr = 16'h0800; mPlus2 = brTarget + 16'd2; mValid = 1'b0;
      end else if (stallCtrl) begin
        mCnt = (mCnt < 16'hFFFF) ? mCnt + 16'd1 : mCnt;
      end else if (halt_ID && mValid) begin
        mHalted = 1'b1; mInstr = 16'h0800; mValid = 1'b0;
      end else begin
        mInstr = mPc; mPlus2 = mPc + 16'd2; mPc = mPc + 16'd2; mValid = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_pc", pc_out, mPc);
    chk("m_instr", instr_IFID, mInstr);
    chk("m_pcPlus2", pcPlus2_IFID, mPlus2);
    chk("m_valid", {15'd0, valid_IFID}, {15'd0, mValid});
    chk("m_halted", {15'd0, halted}, {15'd0, mHalted});
    chk("m_stallCnt", stallCnt, mCnt);
    chk("m_rd1", {13'd0, Rd1Addr_IFID}, {13'd0, mInstr[10:8]});
    chk("m_rd2", {13'd0, Rd2Addr_IFID}, {13'd0, mInstr[7:5]});
    chk("m_bubble", {15'd0, bubble}, {15'd0, stallCtrl & ~brTaken & ~mHalted});
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; stallCtrl = 1'b0; brTaken = 1'b0; halt_ID = 1'b0; brTarget = 16'h0000;
    tick; tick;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_instr", instr_IFID, 16'h0800);
    chk("rst_pcPlus2", pcPlus2_IFID, 16'h0002);
    chk("rst_valid", {15'd0, valid_IFID}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_cnt", stallCnt, 16'h0000);
    rst = 1'b1;

    // free run
    tick;
    chk("run1_pc", pc_out, 16'h0002);
    chk("run1_instr", instr_IFID, 16'h0000);
    chk("run1_valid", {15'd0, valid_IFID}, 16'd1);
    tick;
    chk("run2_pc", pc_out, 16'h0004);
    chk("run2_instr", instr_IFID, 16'h0002);
    tick;
    chk("run3_pc", pc_out, 16'h0006);
    chk("run3_instr", instr_IFID, 16'h0004);
    repeat (5) tick;
    chk("prestall_pc", pc_out, 16'h0010);
    chk("prestall_instr", instr_IFID, 16'h000E);

    // two-cycle stall
    stallCtrl = 1'b1;
    #1 chk("stall_bubble", {15'd0, bubble}, 16'd1);
    tick;
    chk("stall1_pc", pc_out, 16'h0010);
    chk("stall1_instr", instr_IFID, 16'h000E);
    tick;
    chk("stall2_pc", pc_out, 16'h0010);
    chk("stall2_cnt", stallCnt, 16'h0002);
    stallCtrl = 1'b0;
    tick;
    chk("resume_pc", pc_out, 16'h0012);
    chk("resume_instr", instr_IFID, 16'h0010);

    // redirect with simultaneous stall
    brTaken = 1'b1; brTarget = 16'h0040; stallCtrl = 1'b1;
    #1 chk("br_bubble", {15'd0, bubble}, 16'd0);
    tick;
    chk("br_pc", pc_out, 16'h0040);
    chk("br_valid", {15'd0, valid_IFID}, 16'd0);
    chk("br_instr", instr_IFID, 16'h0800);
    chk("br_pcPlus2", pcPlus2_IFID, 16'h0042);
    chk("br_cnt", stallCnt, 16'h0002);
    brTaken = 1'b0; stallCtrl = 1'b0;
    tick;
    chk("tgt_pc", pc_out, 16'h0042);
    chk("tgt_instr", instr_IFID, 16'h0040);

    // halt, then ignored pulses
    halt_ID = 1'b1;
    tick;
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_pc", pc_out, 16'h0042);
    chk("halt_instr", instr_IFID, 16'h0800);
    halt_ID = 1'b0; brTaken = 1'b1; brTarget = 16'h0100; stallCtrl = 1'b1;
    #1 chk("halt_bubble", {15'd0, bubble}, 16'd0);
    tick; tick;
    chk("halt_hold_pc", pc_out, 16'h0042);
    chk("halt_hold_cnt", stallCnt, 16'h0002);
    brTaken = 1'b0; stallCtrl = 1'b0;
    rst = 1'b0;
    #1 chk("halt_rst_pc", pc_out, 16'h0000);
    chk("halt_rst_halted", {15'd0, halted}, 16'd0);
    tick;
    rst = 1'b1;
    tick;
    chk("after_rst_pc", pc_out, 16'h0002);

    // PC wrap
    brTaken = 1'b1; brTarget = 16'hFFFE;
    tick;
    chk("wrap_pre_pc", pc_out, 16'hFFFE);
    brTaken = 1'b0;
    tick;
    chk("wrap_pc", pc_out, 16'h0000);
    chk("wrap_instr", instr_IFID, 16'hFFFE);
    chk("wrap_pcPlus2", pcPlus2_IFID, 16'h0000);

    // asynchronous reset between edges during a stall
    stallCtrl = 1'b1;
    tick; tick;
    #3 rst = 1'b0;
    #1 chk("arst_pc", pc_out, 16'h0000);
    chk("arst_cnt", stallCnt, 16'h0000);
    chk("arst_instr", instr_IFID, 16'h0800);
    chk("arst_valid", {15'd0, valid_IFID}, 16'd0);
    tick;
    rst = 1'b1;

    // counter saturation via a long stall
    repeat (65540) tick;
    chk("sat_cnt", stallCnt, 16'hFFFF);
    tick;
    chk("sat_hold_cnt", stallCnt, 16'hFFFF);
    stallCtrl = 1'b0;
    tick;
    chk("sat_after_cnt", stallCnt, 16'hFFFF);
    chk("sat_after_pc", pc_out, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Fetch stage and IF/ID pipeline register for the 5-stage 16-bit pipeline. It holds the PC, latches the fetched instruction into IF/ID, and acts on the hazard unit's stall request (PC and IF/ID hold, ID/EX receives a bubble). It also handles the EX-resolved branch redirect with flush and a terminal HALT state. It exports the decode-stage source register addresses that the hazard detector compares against in-flight writers.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- NOP_INSTR, 16'h0800, encoding placed in IF/ID on flush or halt.

Ports:
- clk  in  1  single pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallCtrl  in  1  stall request from the hazard detector.
- brTaken  in  1  branch/jump resolved taken in EX this cycle.
- brTarget  in  16  redirect address, valid when brTaken=1.
- halt_ID  in  1  decode recognises HALT in the IF/ID instruction.
- instr_mem  in  16  instruction memory read data for address pc_out, combinational.
- pc_out  out  16  current fetch address (registered).
- instr_IFID  out  16  IF/ID instruction.
- pcPlus2_IFID  out  16  IF/ID copy of fetch PC + 2.
- valid_IFID  out  1  IF/ID holds a real instruction.
- Rd1Addr_IFID  out  3  instr_IFID[10:8].
- Rd2Addr_IFID  out  3  instr_IFID[7:5].
- bubble  out  1  ID/EX must load a NOP this cycle.
- halted  out  1  fetch is frozen in HALT.
- stallCnt  out  16  saturating count of stalled cycles.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Per-edge priority in RUN: brTaken > stallCtrl > halt > normal.
- brTaken=1:
  - pc_out <= brTarget.
  - IF/ID flushes: instr_IFID <= NOP_INSTR, valid_IFID <= 0, pcPlus2_IFID <= brTarget + 2.
  - stallCtrl is ignored that cycle.
- stallCtrl=1, brTaken=0:
  - pc_out and all IF/ID registers hold.
  - stallCnt increments, saturating at 16'hFFFF with no wrap.
- halt_ID=1 & valid_IFID=1, with stallCtrl=0 and brTaken=0:
  - Transition to HALT.
  - pc_out holds.
  - IF/ID loads NOP_INSTR with valid_IFID <= 0.
- Normal (none of the above):
  - pc_out <= pc_out + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
  - instr_IFID <= instr_mem, pcPlus2_IFID <= pc_out + 2, valid_IFID <= 1.
- HALT:
  - All registers hold and halted=1.
  - brTaken, stallCtrl and halt_ID are ignored; stallCnt does not count.
  - Exit is by rst only.
- bubble = stallCtrl & ~brTaken & (state==RUN). Combinational.
- Rd1Addr_IFID and Rd2Addr_IFID are always the raw instruction fields. Qualifying them with valid_IFID is the consumer's job.

## Timing
- Reset values (asynchronous, while rst=0):
  - pc_out=RESET_PC, instr_IFID=NOP_INSTR, pcPlus2_IFID=RESET_PC+2.
  - valid_IFID=0, halted=0, stallCnt=0, state=RUN.
- Reset is honoured mid-stall, mid-flush and in HALT. The first edge after rst deasserts performs a normal fetch of RESET_PC.
- Fetch-to-IF/ID latency is 1 cycle: the instruction at address A appears in instr_IFID on the edge after pc_out=A.
- A stall holds for exactly as many cycles as stallCtrl is high. The next edge after it drops resumes normal fetch with no lost or duplicated instruction.
- Redirect penalty: the IF/ID slot is invalid for 1 cycle. The target instruction is in IF/ID 2 edges after brTaken is sampled.
- halted rises on the edge that samples the HALT condition. It is registered, not combinational.
- stallCtrl and brTaken high in the same cycle:
  - The redirect wins, bubble=0, and stallCnt does not increment.

## Test plan
- Reset then free-run with memory returning data=address:
  - pc_out steps 0,2,4,6.
  - instr_IFID lags by one edge.
  - valid_IFID rises at the first edge.
- stallCtrl held 2 cycles with pc_out=16'h0010 and instr_IFID=16'h000E:
  - Both values hold for 2 edges, bubble=1 during both, stallCnt=2.
  - Next edge gives pc_out=16'h0012 and instr_IFID=16'h0010.
- brTaken=1, brTarget=16'h0040, with stallCtrl=1 in the same cycle:
  - pc_out=16'h0040, valid_IFID=0, instr_IFID=16'h0800, bubble=0.
  - Next edge gives pc_out=16'h0042 and instr_IFID=mem[16'h0040].
- halt_ID=1 with valid_IFID=1:
  - halted=1 and pc_out is frozen.
  - Later brTaken/stallCtrl pulses cause no change.
  - rst low then high returns pc_out to 16'h0000.
- PC wrap and counter saturation:
  - pc_out=16'hFFFE with a normal edge gives 16'h0000.
  - stallCnt preloaded near saturation (via a long stall) stops at 16'hFFFF.
- Asynchronous reset asserted mid-stall between clock edges:
  - Outputs reach reset values immediately, without waiting for a clock edge.
